present_sbox_layer_serial_masked: RTL

Nibble-serial, d-share masked PRESENT substitution layer for the 80-bit-key encryption datapath. Accepts a full shared 64-bit state, streams its 16 nibbles one per cycle through a pipelined glitch-robust (GHPC-style) masked S-box core, and reassembles the shared result. Generalises the single-nibble masked S-box stage in share count, state width and core latency, and adds load/busy/done sequencing and per-nibble randomness handshaking. Sits between the key-addition and permutation stages of the round controller.

---
 rtl/present_masked_pkg.sv | 36 +++
 rtl/present_sbox_core_masked.sv | 97 +++++++++
 rtl/present_sbox_layer_serial_masked.sv | 103 ++++++++++
 3 files changed

// File: rtl/present_masked_pkg.sv
// Shared constants and helpers for the masked PRESENT S-box layer.
package present_masked_pkg;

    localparam int NIBBLES_DEF = 16;
    localparam int W_DEF       = 4 * NIBBLES_DEF;

    // Nibble i of this constant is S(i).
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int rand_width(input int shares);
        return 4 * shares * (shares - 1) / 2;
    endfunction

    // Bit 16*j+m is set when monomial m (bit set of input bits) appears in output bit j.
    function automatic logic [63:0] sbox_anf();
        logic [15:0] t;
        logic [63:0] res;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            for (int x = 0; x < 16; x++) t[x] = SBOX[4*x+j];
            for (int b = 0; b < 4; b++)
                for (int m = 0; m < 16; m++)
                    if (m[b]) t[m] = t[m] ^ t[m ^ (1 << b)];
            res[16*j +: 16] = t;
        end
        return res;
    endfunction

endpackage

// File: rtl/present_sbox_core_masked.sv
// One shared nibble through the masked PRESENT S-box; CORE_LAT cycles, no stall.
// Cross-domain products are blinded with fresh r before the first register.
module present_sbox_core_masked
    import present_masked_pkg::*;
#(
    parameter int SHARES      = 2,
    parameter int CORE_LAT    = 1,
    parameter int LOW_LATENCY = 0,
    parameter int RAND_W      = rand_width(SHARES)
) (
    input  logic                  clk,
    input  logic [4*SHARES-1:0]   x,
    input  logic [RAND_W-1:0]     r,
    output logic [4*SHARES-1:0]   y
);
    localparam logic [63:0] ANF   = sbox_anf();
    localparam int          EXTRA = (CORE_LAT > 1) ? CORE_LAT - 1 : 1;

    logic [3:0]          xs      [SHARES];
    logic [3:0]          lin     [SHARES];
    logic [3:0]          xdom    [SHARES];
    logic [3:0]          lin_q   [SHARES];
    logic [3:0]          xdom_q  [SHARES];
    logic [4*SHARES-1:0] y1;
    logic [4*SHARES-1:0] dly_q   [EXTRA];
    logic [RAND_W-1:0]   rr;
    logic                term;
    logic                same;
    int                  first;

    always_comb begin
        rr    = r;
        term  = 1'b0;
        same  = 1'b0;
        first = 0;
        for (int s = 0; s < SHARES; s++) begin
            xs[s]   = x[4*s +: 4];
            lin[s]  = '0;
            xdom[s] = '0;
        end
        for (int j = 0; j < 4; j++) begin
            if (ANF[16*j]) lin[0][j] = ~lin[0][j];
            // Expand each monomial over share tuples; a term lands in the share of its lowest variable.
            for (int m = 1; m < 16; m++) begin
                if (ANF[16*j+m]) begin
                    for (int a = 0; a < SHARES; a++)
                    for (int b = 0; b < SHARES; b++)
                    for (int c = 0; c < SHARES; c++)
                    for (int d = 0; d < SHARES; d++) begin
                        if ((m[0] || a == 0) && (m[1] || b == 0) && (m[2] || c == 0) && (m[3] || d == 0)) begin
                            term  = (!m[0] || xs[a][0]) && (!m[1] || xs[b][1]) &&
                                    (!m[2] || xs[c][2]) && (!m[3] || xs[d][3]);
                            first = m[0] ? a : (m[1] ? b : (m[2] ? c : d));
                            same  = (!m[0] || a == first) && (!m[1] || b == first) &&
                                    (!m[2] || c == first) && (!m[3] || d == first);
                            for (int s = 0; s < SHARES; s++) begin
                                if (s == first) begin
                                    if (same) lin[s][j]  = lin[s][j] ^ term;
                                    else      xdom[s][j] = xdom[s][j] ^ term;
                                end
                            end
                        end
                    end
                end
            end
            for (int i = 0; i < SHARES; i++) begin
                for (int k = i + 1; k < SHARES; k++) begin
                    xdom[i][j] = xdom[i][j] ^ rr[0];
                    xdom[k][j] = xdom[k][j] ^ rr[0];
                    rr = rr >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < SHARES; s++) begin
            if (LOW_LATENCY != 0) begin
                xdom_q[s] <= xdom[s] ^ lin[s];
                lin_q[s]  <= '0;
            end else begin
                xdom_q[s] <= xdom[s];
                lin_q[s]  <= lin[s];
            end
        end
        dly_q[0] <= y1;
        for (int l = 1; l < EXTRA; l++) dly_q[l] <= dly_q[l-1];
    end

    always_comb begin
        y1 = '0;
        for (int s = 0; s < SHARES; s++) y1[4*s +: 4] = xdom_q[s] ^ lin_q[s];
    end

    assign y = (CORE_LAT > 1) ? dly_q[EXTRA-1] : y1;

endmodule

// File: rtl/present_sbox_layer_serial_masked.sv
// Nibble-serial masked PRESENT S-box layer; start-to-done NIBBLES+CORE_LAT+1 cycles.
// No backpressure: r must be valid whenever r_req is high; start is ignored unless idle.
module present_sbox_layer_serial_masked
    import present_masked_pkg::*;
#(
    parameter int SHARES      = 2,
    parameter int NIBBLES     = NIBBLES_DEF,
    parameter int CORE_LAT    = 1,
    parameter int LOW_LATENCY = 0,
    parameter int RAND_W      = rand_width(SHARES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [SHARES*4*NIBBLES-1:0] state_in,
    input  logic [RAND_W-1:0]           r,
    output logic                        r_req,
    output logic                        busy,
    output logic                        done,
    output logic [SHARES*4*NIBBLES-1:0] state_out
);
    localparam int             W          = 4 * NIBBLES;
    localparam int             CW         = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0]  LAST       = CW'(NIBBLES - 1);
    localparam logic [CW-1:0]  DRAIN_LAST = CW'(CORE_LAT - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       out_idx_q;
    logic [W-1:0]        sreg_q [SHARES];
    logic [CORE_LAT-1:0] vld_q;
    logic [4*SHARES-1:0] core_x;
    logic [4*SHARES-1:0] core_y;
    logic                issue;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FEED;
            ST_FEED:  if (cnt_q == LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == DRAIN_LAST) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        issue = (state_q == ST_FEED);
        r_req = issue;
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
    end

    always_comb begin
        core_x = '0;
        for (int s = 0; s < SHARES; s++) core_x[4*s +: 4] = sreg_q[s][3:0];
    end

    present_sbox_core_masked #(
        .SHARES      (SHARES),
        .CORE_LAT    (CORE_LAT),
        .LOW_LATENCY (LOW_LATENCY),
        .RAND_W      (RAND_W)
    ) u_core (
        .clk (clk),
        .x   (core_x),
        .r   (r),
        .y   (core_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_idx_q <= '0;
            vld_q     <= '0;
            state_out <= '0;
            for (int s = 0; s < SHARES; s++) sreg_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            vld_q[0] <= issue;
            for (int l = 1; l < CORE_LAT; l++) vld_q[l] <= vld_q[l-1];
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q     <= '0;
                        out_idx_q <= '0;
                        for (int s = 0; s < SHARES; s++) sreg_q[s] <= state_in[W*s +: W];
                    end
                end
                ST_FEED: begin
                    for (int s = 0; s < SHARES; s++) sreg_q[s] <= sreg_q[s] >> 4;
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
                ST_DRAIN: cnt_q <= cnt_q + 1'b1;
                default:  cnt_q <= '0;
            endcase
            // Each share's result nibble goes back to the same position in its own share.
            if (vld_q[CORE_LAT-1]) begin
                for (int s = 0; s < SHARES; s++) state_out[W*s + 4*out_idx_q +: 4] <= core_y[4*s +: 4];
                out_idx_q <= (out_idx_q == LAST) ? '0 : out_idx_q + 1'b1;
            end
        end
    end

endmodule
